// File: rtl/jump_control_unit.sv
// rtl/jump_control_unit.sv - jump/RET/interrupt-vector PC control with return stack; JMPCTL_NESTED_IRQ_EN enables nesting
module jump_control_unit #(
    parameter int               ADDR_W      = 8,
    parameter int               INS_W       = 20,
    parameter int               NUM_IRQ     = 4,
    parameter int               STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 8'hF0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INS_W-1:0]   ins,
    input  logic [ADDR_W-1:0]  current_address,
    input  logic [3:0]         flag_ex,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               pc_mux_sel,
    output logic [ADDR_W-1:0]  jmp_loc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_service,
    output logic               stack_err
);
    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    typedef enum logic {RUN, SHADOW} state_t;

    state_t              state, state_d;
    logic [NUM_IRQ-1:0]  irq_q, pending, rise, eligible, pick, ack_d;
    logic [SP_W-1:0]     sp, sp_m1;
    logic [IDX_W-1:0]    push_idx, top_idx;
    logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];
    logic [4:0]          opcode;
    logic [ADDR_W-1:0]   target, vec, jmp_d;
    logic [2:0]          sel;
    logic                is_jmp, is_ret, stack_empty, stack_full;
    logic                push, pop, pc_d, err_d;
    logic                unused_ins;

    assign opcode      = ins[INS_W-1 -: 5];
    assign target      = ins[ADDR_W-1:0];
    assign unused_ins  = ^ins;
    assign rise        = irq & ~irq_q;
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign sp_m1       = sp - SP_W'(1);
    assign top_idx     = sp_m1[IDX_W-1:0];
    assign push_idx    = sp[IDX_W-1:0];
    assign in_service  = !stack_empty;
    assign vec         = VEC_BASE + ADDR_W'({sel, 1'b0});

    // Conditional jumps test flag_ex = {Z,C,N,V}
    always_comb begin
        is_jmp = 1'b0;
        is_ret = 1'b0;
        case (opcode)
            5'b11000: is_jmp = 1'b1;
            5'b11100: is_jmp = flag_ex[3];
            5'b11101: is_jmp = flag_ex[2];
            5'b11110: is_jmp = flag_ex[1];
            5'b11111: is_jmp = flag_ex[0];
            5'b10000: is_ret = 1'b1;
            default:  ;
        endcase
    end

`ifdef JMPCTL_NESTED_IRQ_EN
    logic [NUM_IRQ-1:0] active_mask [STACK_DEPTH];
    logic [NUM_IRQ-1:0] active_any;
    logic               blocked;

    // A channel may preempt only if it outranks every level currently active
    always_comb begin
        active_any = '0;
        for (int i = 0; i < STACK_DEPTH; i++) active_any = active_any | active_mask[i];
        blocked  = 1'b0;
        eligible = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            blocked     = blocked | active_any[k];
            eligible[k] = pending[k] & ~blocked & ~stack_full;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) active_mask[i] <= '0;
        end else if (push) begin
            active_mask[push_idx] <= ack_d;
        end else if (pop) begin
            active_mask[top_idx] <= '0;
        end
    end
`else
    assign eligible = (in_service || stack_full) ? '0 : pending;
`endif

    always_comb begin
        pick = '0;
        sel  = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                pick    = '0;
                pick[k] = 1'b1;
                sel     = 3'(k);
            end
        end
    end

    // Instruction jumps outrank interrupts; an empty-stack RET falls through to interrupt entry
    always_comb begin
        state_d = state;
        pc_d    = 1'b0;
        jmp_d   = jmp_loc;
        ack_d   = '0;
        err_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (state == RUN) begin
            if (is_jmp) begin
                pc_d    = 1'b1;
                jmp_d   = target;
                state_d = SHADOW;
            end else if (is_ret && !stack_empty) begin
                pop     = 1'b1;
                pc_d    = 1'b1;
                jmp_d   = stack_mem[top_idx];
                state_d = SHADOW;
            end else begin
                err_d = is_ret;
                if (|pick) begin
                    push    = 1'b1;
                    pc_d    = 1'b1;
                    jmp_d   = vec;
                    ack_d   = pick;
                    state_d = SHADOW;
                end
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            pc_mux_sel <= 1'b0;
            jmp_loc    <= '0;
            irq_ack    <= '0;
            stack_err  <= 1'b0;
            pending    <= '0;
            irq_q      <= '0;
            sp         <= '0;
        end else begin
            state      <= state_d;
            pc_mux_sel <= pc_d;
            jmp_loc    <= jmp_d;
            irq_ack    <= ack_d;
            stack_err  <= err_d;
            irq_q      <= irq;
            pending    <= (pending & ~ack_d) | rise;
            if (push)     sp <= sp + SP_W'(1);
            else if (pop) sp <= sp_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack_mem[push_idx] <= current_address;
    end
endmodule

// File: tb/tb_jump_control_unit.sv
// tb/tb_jump_control_unit.sv - directed self-checking bench for jump_control_unit
module tb_jump_control_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ins;
    logic [7:0]  current_address;
    logic [3:0]  flag_ex;
    logic [3:0]  irq;
    logic        pc_mux_sel;
    logic [7:0]  jmp_loc;
    logic [3:0]  irq_ack;
    logic        in_service;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    localparam logic [19:0] NOP = 20'h00000;
    localparam logic [19:0] RET = 20'h80000;

    jump_control_unit dut (
        .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
        .flag_ex(flag_ex), .irq(irq), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc),
        .irq_ack(irq_ack), .in_service(in_service), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ins = NOP; current_address = '0; flag_ex = '0; irq = '0;
        step(); step();
        checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL rst_pc got=%b exp=0", pc_mux_sel); end
        checks++; if (jmp_loc !== 8'h00) begin errors++; $display("FAIL rst_jmp got=%h exp=00", jmp_loc); end
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got=%b exp=0000", irq_ack); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_insvc got=%b exp=0", in_service); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", stack_err); end
        reset = 1'b0;
        step();
        checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL post_rst_pc got=%b exp=0", pc_mux_sel); end
    endtask

    task automatic test_jmp();
        ins = 20'hC0008;
        step();
        checks++; if (pc_mux_sel !== 1'b1) begin errors++; $display("FAIL jmp_pc got=%b exp=1", pc_mux_sel); end
        checks++; if (jmp_loc !== 8'h08) begin errors++; $display("FAIL jmp_loc got=%h exp=08", jmp_loc); end
        step();
        checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL jmp_shadow_pc got=%b exp=0", pc_mux_sel); end
        checks++; if (jmp_loc !== 8'h08) begin errors++; $display("FAIL jmp_shadow_hold got=%h exp=08", jmp_loc); end
        ins = 20'h40012;
        step();
        checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL nonjump_pc got=%b exp=0", pc_mux_sel); end
        checks++; if (jmp_loc !== 8'h08) begin errors++; $display("FAIL nonjump_hold got=%h exp=08", jmp_loc); end
        ins = NOP;
    endtask

    task automatic test_conditional();
        logic [19:0] c_ins  [5] = '{20'hE0008, 20'hE0008, 20'hE8033, 20'hF0044, 20'hF8055};
        logic [3:0]  c_flag [5] = '{4'h8, 4'h0, 4'h4, 4'h2, 4'hE};
        logic        c_take [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  c_loc  [5] = '{8'h08, 8'h08, 8'h33, 8'h44, 8'h44};
        for (int i = 0; i < 5; i++) begin
            ins = c_ins[i]; flag_ex = c_flag[i];
            step();
            checks++; if (pc_mux_sel !== c_take[i]) begin errors++; $display("FAIL cond_pc[%0d] got=%b exp=%b", i, pc_mux_sel, c_take[i]); end
            checks++; if (jmp_loc !== c_loc[i]) begin errors++; $display("FAIL cond_loc[%0d] got=%h exp=%h", i, jmp_loc, c_loc[i]); end
            ins = NOP; flag_ex = '0;
            step();
        end
    endtask

    task automatic test_irq_entry_ret();
        current_address = 8'h04; irq = 4'b0100;
        step();
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL irq_early_ack got=%b exp=0000", irq_ack); end
        step();
        checks++; if (irq_ack !== 4'b0100) begin errors++; $display("FAIL irq_ack got=%b exp=0100", irq_ack); end
        checks++; if (pc_mux_sel !== 1'b1) begin errors++; $display("FAIL irq_pc got=%b exp=1", pc_mux_sel); end
        checks++; if (jmp_loc !== 8'hF4) begin errors++; $display("FAIL irq_vec got=%h exp=f4", jmp_loc); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL irq_insvc got=%b exp=1", in_service); end
        step();
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL irq_ack_pulse got=%b exp=0000", irq_ack); end
        checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL irq_shadow_pc got=%b exp=0", pc_mux_sel); end
        step();
        ins = RET; current_address = 8'h77;
        step();
        checks++; if (pc_mux_sel !== 1'b1) begin errors++; $display("FAIL ret_pc got=%b exp=1", pc_mux_sel); end
        checks++; if (jmp_loc !== 8'h04) begin errors++; $display("FAIL ret_loc got=%h exp=04", jmp_loc); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL ret_insvc got=%b exp=0", in_service); end
        ins = NOP;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL held_level_ack[%0d] got=%b exp=0000", i, irq_ack); end
        end
        irq = '0;
        step();
    endtask

    task automatic test_simultaneous();
        ins = 20'hC0010; irq = 4'b1001; current_address = 8'h21;
        step();
        checks++; if (jmp_loc !== 8'h10 || pc_mux_sel !== 1'b1) begin errors++; $display("FAIL sim_jmp got=%h/%b exp=10/1", jmp_loc, pc_mux_sel); end
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL sim_jmp_ack got=%b exp=0000", irq_ack); end
        ins = NOP;
        step();
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL sim_shadow_ack got=%b exp=0000", irq_ack); end
        step();
        checks++; if (irq_ack !== 4'b0001) begin errors++; $display("FAIL sim_irq0_ack got=%b exp=0001", irq_ack); end
        checks++; if (jmp_loc !== 8'hF0) begin errors++; $display("FAIL sim_irq0_vec got=%h exp=f0", jmp_loc); end
        step(); step();
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL sim_irq3_blocked got=%b exp=0000", irq_ack); end
        ins = RET;
        step();
        checks++; if (jmp_loc !== 8'h21) begin errors++; $display("FAIL sim_ret_loc got=%h exp=21", jmp_loc); end
        ins = NOP;
        step();
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL sim_ret_shadow_ack got=%b exp=0000", irq_ack); end
        step();
        checks++; if (irq_ack !== 4'b1000) begin errors++; $display("FAIL sim_irq3_ack got=%b exp=1000", irq_ack); end
        checks++; if (jmp_loc !== 8'hF6) begin errors++; $display("FAIL sim_irq3_vec got=%h exp=f6", jmp_loc); end
        step();
        ins = RET; step();
        ins = NOP; step();
        irq = '0; step();
    endtask

    task automatic test_empty_ret();
        ins = RET;
        step();
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL empty_ret_err got=%b exp=1", stack_err); end
        checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL empty_ret_pc got=%b exp=0", pc_mux_sel); end
        ins = NOP;
        step();
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL empty_ret_pulse got=%b exp=0", stack_err); end
    endtask

    task automatic test_nesting();
`ifdef JMPCTL_NESTED_IRQ_EN
        for (int k = 3; k >= 0; k--) begin
            current_address = 8'(8'h30 + k); irq[k] = 1'b1;
            step(); step();
            checks++; if (irq_ack !== 4'(1 << k)) begin errors++; $display("FAIL nest_ack[%0d] got=%b exp=%b", k, irq_ack, 4'(1 << k)); end
            checks++; if (jmp_loc !== 8'(8'hF0 + 2 * k)) begin errors++; $display("FAIL nest_vec[%0d] got=%h exp=%h", k, jmp_loc, 8'(8'hF0 + 2 * k)); end
            step();
        end
        irq[3] = 1'b0; step();
        irq[3] = 1'b1; step(); step(); step();
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL nest_full_ack got=%b exp=0000", irq_ack); end
        for (int j = 0; j < 4; j++) begin
            ins = RET;
            step();
            checks++; if (jmp_loc !== 8'(8'h30 + j)) begin errors++; $display("FAIL nest_ret[%0d] got=%h exp=%h", j, jmp_loc, 8'(8'h30 + j)); end
            ins = NOP;
            step();
        end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL nest_unwound got=%b exp=0", in_service); end
        step();
        checks++; if (irq_ack !== 4'b1000) begin errors++; $display("FAIL nest_fifth_ack got=%b exp=1000", irq_ack); end
        step();
`else
        current_address = 8'h40; irq = 4'b0100;
        step(); step();
        checks++; if (irq_ack !== 4'b0100) begin errors++; $display("FAIL flat_ack2 got=%b exp=0100", irq_ack); end
        step();
        irq = 4'b0110;
        step(); step(); step();
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL flat_no_preempt got=%b exp=0000", irq_ack); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL flat_insvc got=%b exp=1", in_service); end
        ins = RET;
        step();
        checks++; if (jmp_loc !== 8'h40) begin errors++; $display("FAIL flat_ret got=%h exp=40", jmp_loc); end
        ins = NOP;
        step(); step();
        checks++; if (irq_ack !== 4'b0010) begin errors++; $display("FAIL flat_ack1 got=%b exp=0010", irq_ack); end
        checks++; if (jmp_loc !== 8'hF2) begin errors++; $display("FAIL flat_vec1 got=%h exp=f2", jmp_loc); end
        step();
`endif
        ins = RET; step();
        ins = NOP; step();
        irq = '0; step();
    endtask

    task automatic test_reset_mid_service();
        current_address = 8'h55; irq = 4'b0001;
        step(); step();
        checks++; if (irq_ack !== 4'b0001 || in_service !== 1'b1) begin errors++; $display("FAIL mid_entry got=%b/%b exp=0001/1", irq_ack, in_service); end
        irq = 4'b0101;
        step();
        reset = 1'b1; irq = '0;
        #2;
        checks++; if (pc_mux_sel !== 1'b0) begin errors++; $display("FAIL mid_rst_pc got=%b exp=0", pc_mux_sel); end
        checks++; if (jmp_loc !== 8'h00) begin errors++; $display("FAIL mid_rst_jmp got=%h exp=00", jmp_loc); end
        checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_ack got=%b exp=0000", irq_ack); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL mid_rst_insvc got=%b exp=0", in_service); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got=%b exp=0", stack_err); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (irq_ack !== 4'b0000 || pc_mux_sel !== 1'b0) begin errors++; $display("FAIL mid_post_rst[%0d] got=%b/%b exp=0000/0", i, irq_ack, pc_mux_sel); end
        end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL mid_post_insvc got=%b exp=0", in_service); end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_conditional();
        test_irq_entry_ret();
        test_simultaneous();
        test_empty_ret();
        test_nesting();
        test_reset_mid_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jump_control_unit.md
JUMP_CONTROL_UNIT -- requirements
Module: jump_control_unit

Interface
REQ-001 Parameter ADDR_W, default 8: program-address width.
REQ-002 Parameter INS_W, default 20: instruction width; opcode = ins[INS_W-1:INS_W-5], target = ins[ADDR_W-1:0].
REQ-003 Parameter NUM_IRQ, default 4: interrupt channel count, 1..8.
REQ-004 Parameter STACK_DEPTH, default 4: return-address stack entries, power of two, at least 2.
REQ-005 Parameter VEC_BASE, default 8'hF0: vector base; channel k vector = VEC_BASE + 2*k, modulo 2^ADDR_W.
REQ-006 Port clk  in  1: the block's one clock; all state changes on its rising edge.
REQ-007 Port reset  in  1: reset, asynchronous and active-high.
REQ-008 Port ins  in  INS_W: instruction in the decode stage.
REQ-009 Port current_address  in  ADDR_W: address of the next sequential instruction; this is the return address.
REQ-010 Port flag_ex  in  4: flags from execute, {Z,C,N,V} in bits [3:0].
REQ-011 Port irq  in  NUM_IRQ: level interrupt requests.
REQ-012 Port pc_mux_sel  out  1: registered; 1 = PC loads jmp_loc.
REQ-013 Port jmp_loc  out  ADDR_W: registered jump target.
REQ-014 Port irq_ack  out  NUM_IRQ: registered one-hot acknowledge pulse.
REQ-015 Port in_service  out  1: one or more interrupts are being serviced.
REQ-016 Port stack_err  out  1: registered one-cycle pulse on a RET issued with an empty stack.

Function
REQ-017 Opcodes: 11000 JMP; 11100 JZ; 11101 JC; 11110 JN; 11111 JV; 10000 RET.
- Any other opcode is not a jump.
- A conditional jump is taken when its flag_ex bit is 1.
REQ-018 A rising edge on irq[k], detected against the previous-cycle sample, sets pending[k]; a level held high sets pending[k] only once.
REQ-019 FSM has two states, RUN and SHADOW.
- In SHADOW, ins is ignored for one cycle; the FSM then returns to RUN unconditionally.
- Pending interrupts are neither accepted nor cleared while in SHADOW.
REQ-020 In RUN, a taken jump or RET registers pc_mux_sel=1 for exactly one cycle (latency 1 cycle) and moves the FSM to SHADOW.
- JMP and the conditional jumps set jmp_loc = target.
- RET sets jmp_loc to the popped stack entry.
REQ-021 In RUN with no taken jump or RET, the lowest-index pending channel that is eligible is accepted; eligibility is defined in REQ-029 to REQ-031.
- current_address is pushed onto the stack.
- pc_mux_sel=1 and jmp_loc = that channel's vector.
- irq_ack[k] pulses for one cycle.
- pending[k] is cleared.
- The FSM moves to SHADOW.
REQ-022 When an instruction jump and an interrupt are both possible in the same RUN cycle, the instruction jump wins and the interrupt stays pending.
REQ-023 When the stack is full, no interrupt is accepted and requests stay pending.
REQ-024 A RET with an empty stack is not a jump: stack_err pulses, pc_mux_sel stays 0, and the FSM stays in RUN.
REQ-025 Stack pointer width is log2(STACK_DEPTH)+1; a push and a pop never occur in the same cycle.
REQ-026 in_service = 1 exactly when the stack is not empty.
REQ-027 When not jumping, pc_mux_sel=0 and jmp_loc holds its last value.

Reset
REQ-028 While reset is asserted the following hold, and the first post-reset cycle is RUN:
- FSM = RUN.
- pc_mux_sel, jmp_loc, irq_ack, pending, irq sample register, stack pointer and stack_err all = 0.
- Stack contents may be left unchanged.
- A reset asserted mid-SHADOW or mid-service discards the return addresses.

Configuration
REQ-029 Macro JMPCTL_NESTED_IRQ_EN enables nesting.
REQ-030 Defined: a per-level active mask is kept alongside the stack.
- A pending channel is eligible only if its index is lower than that of every active channel.
- RET clears the most recently entered level.
REQ-031 Undefined: no interrupt is accepted while in_service=1; nesting depth is effectively 1.

Verification
REQ-032 Jumps (defaults, reset released, RUN):
- ins=20'hC0008 -> next cycle pc_mux_sel=1, jmp_loc=8'h08; one SHADOW cycle with pc_mux_sel=0 even if ins is unchanged.
- ins=20'hE0008 (JZ) with flag_ex=4'h8 -> taken to 8'h08; with flag_ex=4'h0 -> pc_mux_sel stays 0.
REQ-033 Interrupt entry and return:
- current_address=8'h04, rising edge on irq[2] -> irq_ack=4'b0100, jmp_loc=8'hF4, in_service=1.
- Later ins=20'h80000 (RET) -> jmp_loc=8'h04, in_service=0.
REQ-034 Simultaneous events: irq[0] and irq[3] rise in the same cycle while ins=20'hC0010 -> jump to 8'h10 first; then irq[0] is accepted after SHADOW (jmp_loc=8'hF0); irq[3] stays pending.
REQ-035 Empty-stack RET: RET after reset -> stack_err one-cycle pulse, pc_mux_sel=0.
REQ-036 Nesting:
- With JMPCTL_NESTED_IRQ_EN: in service of irq[2], irq[1] preempts and pushes a second entry; 4 nested entries fill the stack and a fifth request stays pending.
- Without the macro: irq[1] waits until RET.
REQ-037 Reset mid-service: reset pulse while in_service=1 -> all outputs 0, in_service=0, and no irq_ack for requests that were pending.
